// File: rtl/avalon_core_regbank_pkg.sv
// Shared types and constants for the Avalon-MM register bank.
// FSM state enum, CTRL/STATUS bit positions, register index helpers.
package avalon_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_ST,
    BUSY,
    CAPTURE
  } fsm_state_t;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_BUSY_BIT  = 1;

  function automatic int ctrl_idx(input int addr_w);
    return (1 << addr_w) - 2;
  endfunction

  function automatic int stat_idx(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/avalon_core_regbank_if.sv
// Avalon-MM slave bus bundle: strobes, address, byte enables, data.
// master drives the request side, slave returns read data/valid.
interface avalon_core_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                AVL_READ;
  logic                AVL_WRITE;
  logic                AVL_CS;
  logic [DATA_W/8-1:0] AVL_BYTE_EN;
  logic [ADDR_W-1:0]   AVL_ADDR;
  logic [DATA_W-1:0]   AVL_WRITEDATA;
  logic [DATA_W-1:0]   AVL_READDATA;
  logic                AVL_READDATAVALID;

  modport master (
    output AVL_READ, AVL_WRITE, AVL_CS,
    output AVL_BYTE_EN, AVL_ADDR,
    output AVL_WRITEDATA,
    input  AVL_READDATA, AVL_READDATAVALID
  );

  modport slave (
    input  AVL_READ, AVL_WRITE, AVL_CS,
    input  AVL_BYTE_EN, AVL_ADDR,
    input  AVL_WRITEDATA,
    output AVL_READDATA, AVL_READDATAVALID
  );
endinterface

// File: rtl/avalon_core_regbank_fsm.sv
// Start/done handshake FSM: start pulse, busy, sticky done, capture.
// Ports: CLK, RESET, start_req, done_clr, core_done -> core_start, busy, done, capture.
module regbank_handshake_fsm
  import avalon_regbank_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic start_req,
  input  logic done_clr,
  input  logic core_done,
  output logic core_start,
  output logic busy,
  output logic done,
  output logic capture
);

  fsm_state_t state;

  // Same-edge strobe: result words load on the BUSY->CAPTURE edge.
  assign capture = (state == BUSY) && core_done;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      if (done_clr) done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_req) begin
            state      <= START_ST;
            core_start <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        START_ST: state <= BUSY;
        BUSY: begin
          if (core_done) begin
            state <= CAPTURE;
            done  <= 1'b1;
          end
        end
        CAPTURE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/avalon_core_regbank.sv
// Avalon-MM register bank fronting a compute core (R/W, result, CTRL/STATUS).
// Ports: CLK, RESET, avl (slave), CORE_START/DONE/RESULT, IRQ, EXPORT_DATA.
module avalon_core_regbank
  import avalon_regbank_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int RES_BASE   = 8,
  parameter int RES_WORDS  = 4,
  parameter int EXPORT_IDX = 0
) (
  input  logic                        CLK,
  input  logic                        RESET,
  avalon_core_regbank_if.slave        avl,
  output logic                        CORE_START,
  input  logic                        CORE_DONE,
  input  logic [DATA_W*RES_WORDS-1:0] CORE_RESULT,
  output logic                        IRQ,
  output logic [DATA_W-1:0]           EXPORT_DATA
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int NB       = DATA_W / 8;
  localparam int CTRL_I   = ctrl_idx(ADDR_W);
  localparam int STAT_I   = stat_idx(ADDR_W);
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(CTRL_I);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STAT_I);

  logic wr, rd, b0;
  logic start_req, done_clr;
  logic busy, done, capture, irq_en;
  logic [DATA_W-1:0] ctrl_word, stat_word;
  logic [NUM_REGS-1:0][DATA_W-1:0] view;

  assign wr = avl.AVL_CS & avl.AVL_WRITE;
  assign rd = avl.AVL_CS & avl.AVL_READ;
  assign b0 = avl.AVL_BYTE_EN[0];

  assign start_req = wr && b0 && avl.AVL_ADDR == CTRL_A
                     && avl.AVL_WRITEDATA[CTRL_START_BIT];
  assign done_clr  = wr && b0 && avl.AVL_ADDR == STAT_A
                     && avl.AVL_WRITEDATA[STAT_DONE_BIT];

  regbank_handshake_fsm u_fsm (
    .CLK        (CLK),
    .RESET      (RESET),
    .start_req  (start_req),
    .done_clr   (done_clr),
    .core_done  (CORE_DONE),
    .core_start (CORE_START),
    .busy       (busy),
    .done       (done),
    .capture    (capture)
  );

  // IRQ_EN updates even when a concurrent START is ignored.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) irq_en <= 1'b0;
    else if (wr && b0 && avl.AVL_ADDR == CTRL_A)
      irq_en <= avl.AVL_WRITEDATA[CTRL_IRQEN_BIT];
  end

  always_comb begin
    ctrl_word = '0;
    stat_word = '0;
    ctrl_word[CTRL_IRQEN_BIT] = irq_en;
    stat_word[STAT_DONE_BIT]  = done;
    stat_word[STAT_BUSY_BIT]  = busy;
  end

  assign view[CTRL_I] = ctrl_word;
  assign view[STAT_I] = stat_word;

  for (genvar g = 0; g < NUM_REGS - 2; g++) begin : g_word
    logic [DATA_W-1:0] q;
    if (g >= RES_BASE && g < RES_BASE + RES_WORDS) begin : g_res
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) q <= '0;
        else if (capture)
          q <= CORE_RESULT[(g-RES_BASE)*DATA_W +: DATA_W];
      end
    end else begin : g_rw
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) q <= '0;
        else if (wr && avl.AVL_ADDR == ADDR_W'(g)) begin
          for (int b = 0; b < NB; b++)
            if (avl.AVL_BYTE_EN[b])
              q[b*8 +: 8] <= avl.AVL_WRITEDATA[b*8 +: 8];
        end
      end
    end
    assign view[g] = q;
  end

  // Read samples pre-edge state, so a same-cycle write is not visible.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      avl.AVL_READDATA      <= '0;
      avl.AVL_READDATAVALID <= 1'b0;
    end else begin
      avl.AVL_READDATAVALID <= rd;
      if (rd) avl.AVL_READDATA <= view[avl.AVL_ADDR];
    end
  end

  assign IRQ         = done & irq_en;
  assign EXPORT_DATA = view[EXPORT_IDX];

endmodule
